// File: rtl/serial_signed_div_pow2.sv
// Iterative signed divide by 2^s: one arithmetic shift per clock, then a single
// fix-up cycle that produces the floor, truncated quotient and remainder.
//
// state | meaning
// IDLE  | waiting for an operand (in_ready=1)
// SHIFT | one arithmetic right shift per edge, collecting shifted-out ones
// FIX   | registers floor, quotient (round toward zero) and remainder
// DONE  | results presented (out_valid=1) until the consumer accepts
module serial_signed_div_pow2 #(
  parameter int N  = 8,
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [SW-1:0] in_shift,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_floor,
  output logic [N-1:0]  out_quot,
  output logic [N-1:0]  out_rem
);

  localparam int NW = $clog2(N + 1);
  localparam int CW = (SW > NW) ? SW : NW;
  localparam logic [CW-1:0] N_C = CW'(N);

  typedef enum logic [1:0] {IDLE, SHIFT, FIX, DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  work_q, work_d;
  logic [N-1:0]  dvd_q, dvd_d;
  logic [SW-1:0] shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sticky_q, sticky_d;
  logic [N-1:0]  floor_q, floor_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  rem_q, rem_d;

  logic [CW-1:0] shift_ext;
  logic [CW-1:0] cnt_init;
  logic [N-1:0]  quot_nx;

  assign shift_ext = CW'(in_shift);
  // Shifting past N bits only replicates the sign, so the count saturates at N.
  assign cnt_init  = (shift_ext > N_C) ? N_C : shift_ext;
  // A negative dividend that lost any one bit was rounded down; step back toward zero.
  assign quot_nx   = work_q + N'(dvd_q[N-1] & sticky_q);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_floor = floor_q;
  assign out_quot  = quot_q;
  assign out_rem   = rem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      work_q   <= '0;
      dvd_q    <= '0;
      shift_q  <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      floor_q  <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      dvd_q    <= dvd_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      floor_q  <= floor_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    dvd_d    = dvd_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    floor_d  = floor_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d   = in_data;
          dvd_d    = in_data;
          shift_d  = in_shift;
          sticky_d = 1'b0;
          cnt_d    = cnt_init;
          state_d  = (cnt_init != '0) ? SHIFT : FIX;
        end
      end
      SHIFT: begin
        work_d   = {work_q[N-1], work_q[N-1:1]};
        sticky_d = sticky_q | work_q[0];
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        floor_d = work_q;
        quot_d  = quot_nx;
        // Wraps modulo 2^N; the shift yields zero once s >= N, leaving rem = dividend.
        rem_d   = dvd_q - (quot_nx << shift_q);
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_signed_div_pow2.sv
// Self-checking bench for serial_signed_div_pow2: integer-division reference model
// with a scoreboard monitor, plus directed vectors with literal expectations.
module tb_serial_signed_div_pow2;

  localparam int N  = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [SW-1:0] in_shift;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_floor;
  logic [N-1:0]  out_quot;
  logic [N-1:0]  out_rem;

  typedef struct packed {
    logic [N-1:0] f;
    logic [N-1:0] q;
    logic [N-1:0] r;
  } res_t;

  res_t exp_q[$];
  int   nchk = 0;
  int   nerr = 0;

  serial_signed_div_pow2 #(.N(N), .SW(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shift  (in_shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_floor (out_floor),
    .out_quot  (out_quot),
    .out_rem   (out_rem)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [N-1:0] d, input int s);
    res_t r;
    int di;
    int p;
    di  = int'($signed(d));
    p   = 1 << s;
    r.f = N'(di >>> s);
    r.q = N'(di / p);
    r.r = N'(di % p);
    return r;
  endfunction

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every cycle results are presented they must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL unexpected_result: got floor=%h quot=%h rem=%h with nothing pending",
                 out_floor, out_quot, out_rem);
      end else begin
        check("sb_floor", out_floor, exp_q[0].f);
        check("sb_quot", out_quot, exp_q[0].q);
        check("sb_rem", out_rem, exp_q[0].r);
        check("sb_in_ready_busy", N'(in_ready), N'(0));
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
  end

  task automatic issue(input logic [N-1:0] d, input logic [SW-1:0] s);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      nchk++;
      nerr++;
      $display("FAIL in_ready_timeout: got in_ready=0 expected 1");
    end
    in_valid = 1'b1;
    in_data  = d;
    in_shift = s;
    @(posedge clk);
    exp_q.push_back(model(d, int'(s)));
    #1;
    in_valid = 1'b0;
    in_data  = N'($urandom);
    in_shift = SW'($urandom);
  endtask

  task automatic wait_valid(input int lat_exp);
    int lat;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
    if (!out_valid) begin
      nchk++;
      nerr++;
      $display("FAIL out_valid_timeout: got no out_valid after %0d cycles expected %0d", lat, lat_exp);
    end else begin
      check("latency", N'(lat), N'(lat_exp));
    end
  endtask

  task automatic release_out(input int stall);
    repeat (stall) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("idle_out_valid", N'(out_valid), N'(0));
    check("idle_in_ready", N'(in_ready), N'(1));
  endtask

  task automatic directed(input logic [N-1:0] d, input logic [SW-1:0] s, input int lat,
                          input logic [N-1:0] ef, input logic [N-1:0] eq, input logic [N-1:0] er);
    issue(d, s);
    wait_valid(lat);
    check("lit_floor", out_floor, ef);
    check("lit_quot", out_quot, eq);
    check("lit_rem", out_rem, er);
    release_out(1);
  endtask

  initial begin
    logic [N-1:0] vals [8];
    logic [N-1:0] hold_f;
    vals = '{8'h00, 8'h01, 8'h81, 8'h7F, 8'hC0, 8'hFE, 8'h80, 8'h35};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shift  = '0;
    out_ready = 1'b0;
    #2;
    check("rst_in_ready", N'(in_ready), N'(1));
    check("rst_out_valid", N'(out_valid), N'(0));
    check("rst_floor", out_floor, N'(0));
    check("rst_quot", out_quot, N'(0));
    check("rst_rem", out_rem, N'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Hand-computed vectors
    directed(8'hF9, 3'd1, 2, 8'hFC, 8'hFD, 8'hFF);
    directed(8'd100, 3'd3, 4, 8'd12, 8'd12, 8'd4);
    directed(8'hF8, 3'd2, 3, 8'hFE, 8'hFE, 8'h00);
    directed(8'h80, 3'd7, 8, 8'hFF, 8'hFF, 8'h00);
    directed(8'hFF, 3'd5, 6, 8'hFF, 8'h00, 8'hFF);
    directed(8'h5A, 3'd0, 1, 8'h5A, 8'h5A, 8'h00);
    directed(8'h7F, 3'd7, 8, 8'h00, 8'h00, 8'h7F);

    // Back-pressure with busy-time input noise, then an operand queued behind the handshake
    issue(8'hA3, 3'd4);
    wait_valid(5);
    hold_f = out_floor;
    check("bp_floor", out_floor, 8'hFA);
    check("bp_quot", out_quot, 8'hFB);
    check("bp_rem", out_rem, 8'hF3);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_data  = N'($urandom);
      in_shift = SW'($urandom);
      check("bp_in_ready", N'(in_ready), N'(0));
      check("bp_hold_floor", out_floor, hold_f);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_data   = 8'h33;
    in_shift  = 3'd2;
    @(negedge clk);
    check("bp_idle_out_valid", N'(out_valid), N'(0));
    check("bp_idle_in_ready", N'(in_ready), N'(1));
    @(posedge clk);
    exp_q.push_back(model(8'h33, 2));
    #1;
    in_valid = 1'b0;
    wait_valid(3);
    check("bp_next_floor", out_floor, 8'h0C);
    check("bp_next_quot", out_quot, 8'h0C);
    check("bp_next_rem", out_rem, 8'h03);
    release_out(0);

    // Asynchronous reset during SHIFT discards the in-flight operation
    issue(8'hC5, 3'd6);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("arst_in_ready", N'(in_ready), N'(1));
    check("arst_out_valid", N'(out_valid), N'(0));
    check("arst_floor", out_floor, N'(0));
    check("arst_quot", out_quot, N'(0));
    check("arst_rem", out_rem, N'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("arst_no_stale", N'(out_valid), N'(0));
    directed(8'hC5, 3'd6, 7, 8'hFF, 8'h00, 8'hC5);

    // Model-checked sweep over dividends and every shift count
    foreach (vals[i]) begin
      for (int s = 0; s < (1 << SW); s++) begin
        issue(vals[i], SW'(s));
        wait_valid(((s < N) ? s : N) + 1);
        release_out(s % 3);
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/serial_signed_div_pow2.md
Name: serial_signed_div_pow2

Overview:
Iterative signed divider by a run-time power of two. It accepts an N-bit two's-complement operand and a shift count through a valid/ready handshake, then performs one arithmetic-right-shift step per clock. It returns three results:
- the floor result (arithmetic shift),
- the C-style truncated quotient (rounded toward zero),
- the remainder, which takes the sign of the dividend.

It sits between the operand source and any consumer needing exact signed division semantics rather than plain shift rounding.

Parameters:
N, 8, operand and result width in bits (N >= 2).
SW, 3, width of the shift-count input. Counts up to 2^SW-1 are legal, including counts >= N.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operand and count are valid.
in_ready  output  1  block can accept an operand.
in_data  input  N  signed dividend.
in_shift  input  SW  unsigned shift count s (divisor = 2^s).
out_valid  output  1  results are valid.
out_ready  input  1  consumer accepts the results.
out_floor  output  N  floor(in_data / 2^s), equal to in_data >>> s.
out_quot  output  N  trunc(in_data / 2^s), rounded toward zero.
out_rem  output  N  in_data - out_quot*2^s; its sign follows the dividend; |rem| < 2^s.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE;
  - in_ready=1, out_valid=0;
  - out_floor/out_quot/out_rem = 0;
  - internal counter, shift register and sticky flag cleared.
  - Reset asserted mid-operation aborts the operation; the in-flight result is discarded and never presented.
- States: IDLE, SHIFT, FIX, DONE.
- in_ready = 1 only in IDLE. out_valid = 1 only in DONE.
- IDLE:
  - Input handshake (in_valid & in_ready) at edge k captures in_data into a work register and latches the dividend copy and s.
  - Sticky cleared; remaining count = min(s, N).
  - Next state: SHIFT if the remaining count > 0, else FIX.
- SHIFT, each edge:
  - work <= {work[N-1], work[N-1:1]};
  - sticky <= sticky | work[0];
  - count decrements.
  - Leave for FIX on the edge where the count reaches 0.
  - Exactly min(s, N) shift edges occur. Counts above N behave as s = N because further shifts leave the work register unchanged.
- FIX, one edge:
  - out_floor <= work;
  - out_quot <= work + 1 if dividend negative and sticky = 1, else work;
  - out_rem <= dividend - (quot << s), computed modulo 2^N; this is 0 shifted-out contribution when s >= N, i.e. rem = dividend.
  - Next state: DONE.
- Latency: out_valid rises after edge k + min(s,N) + 1. Example: s = 0 gives 1 cycle; s = 3 gives 4 cycles.
- DONE:
  - Outputs held stable while out_ready = 0, for arbitrary stall length.
  - Output handshake → IDLE at that edge; out_valid drops, in_ready rises.
  - No new input is accepted in the same cycle as the output handshake.
- in_data and in_shift are ignored outside IDLE. Changing them while busy must not affect results.
- Width rule: all arithmetic is N-bit two's complement. Remainder subtraction wraps; the mathematically correct remainder always fits in N bits.
- Boundary case, most-negative dividend: -2^(N-1) with s = N-1 gives quot = -1. With s >= N it gives quot = 0 and rem = dividend.

Test Plan:
1. N=8, in_data=0xF9 (-7), s=1 → floor=0xFC (-4), quot=0xFD (-3), rem=0xFF (-1); out_valid 2 cycles after accept.
2. in_data=100, s=3 → floor=12, quot=12, rem=4; in_data=-8 (0xF8), s=2 → floor=quot=0xFE, rem=0 (sticky clear, no correction).
3. in_data=0x80 (-128), s=7 → floor=quot=0xFF, rem=0; in_data=0xFF (-1), s=5 → floor=0xFF, quot=0, rem=0xFF.
4. s=0, in_data=0x5A → all three outputs = 0x5A/0x5A/0x00, latency 1 cycle; then s=7 with in_data=0x7F → quot=0, floor=0, rem=0x7F.
5. Back-pressure: hold out_ready=0 for 10 cycles in DONE with in_valid=1 and in_data toggling → outputs and in_ready=0 stable; release → one handshake, IDLE next cycle, then the next operand accepted.
6. Assert rst_n=0 asynchronously during SHIFT (s=6) → in_ready=1, out_valid=0, outputs 0 immediately. After release, a fresh operation completes with correct values and no stale result emitted.
